// File: rtl/inv_drive_seq.sv
// Thermometer ramp sequencer for a segmented inverter driver; optional KILL input under INV_DRIVE_SEQ_KILL_EN.
// Latency: first slice change on the edge EN is sampled, then one change per STEP+1 cycles; no backpressure.
`timescale 1ns/1ps
module inv_drive_seq #(
    parameter int SEGS   = 8,
    parameter int STEP_W = 4,
    parameter int LVL_W  = $clog2(SEGS+1)
) (
    input  logic              clk,
    input  logic              rn,
    input  logic              en,
    input  logic [STEP_W-1:0] step,
`ifdef INV_DRIVE_SEQ_KILL_EN
    input  logic              kill,
`endif
    output logic [SEGS-1:0]   seg_en,
    output logic [LVL_W-1:0]  level,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        S_OFF       = 2'd0,
        S_RAMP_UP   = 2'd1,
        S_ON        = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [LVL_W-1:0]  LVL_ONE = LVL_W'(1);
    localparam logic [LVL_W-1:0]  LVL_MAX = LVL_W'(SEGS);
    localparam logic [STEP_W-1:0] CNT_ONE = STEP_W'(1);

    state_t            state_q;
    state_t            state_nxt;
    logic [STEP_W-1:0] cnt_q;
    logic [STEP_W-1:0] cnt_nxt;
    logic [LVL_W-1:0]  level_nxt;
    logic [LVL_W-1:0]  level_step;
    logic [SEGS-1:0]   seg_en_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    always_ff @(posedge clk or negedge rn) begin
        if (!rn) begin
            state_q <= S_OFF;
            cnt_q   <= '0;
            level   <= '0;
            seg_en  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_nxt;
            cnt_q   <= cnt_nxt;
            level   <= level_nxt;
            seg_en  <= seg_en_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
        end
    end

    always_comb begin
        state_nxt  = state_q;
        cnt_nxt    = cnt_q;
        level_nxt  = level;
        done_nxt   = 1'b0;
        seg_en_nxt = '0;
        // A ramp always moves toward the current EN target, so a reversal
        // mid-ramp takes effect at the next dwell expiry.
        level_step = en ? (level + LVL_ONE) : (level - LVL_ONE);

        case (state_q)
            S_OFF: begin
                if (en) begin
                    state_nxt = S_RAMP_UP;
                    level_nxt = LVL_ONE;
                    cnt_nxt   = step;
                end
            end
            S_ON: begin
                if (!en) begin
                    state_nxt = S_RAMP_DOWN;
                    level_nxt = LVL_MAX - LVL_ONE;
                    cnt_nxt   = step;
                end
            end
            S_RAMP_UP, S_RAMP_DOWN: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_ONE;
                end else begin
                    level_nxt = level_step;
                    if (level_step == LVL_MAX) begin
                        state_nxt = S_ON;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else if (level_step == '0) begin
                        state_nxt = S_OFF;
                        cnt_nxt   = '0;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = en ? S_RAMP_UP : S_RAMP_DOWN;
                        cnt_nxt   = step;
                    end
                end
            end
            default: begin
                state_nxt = S_OFF;
                level_nxt = '0;
                cnt_nxt   = '0;
            end
        endcase

`ifdef INV_DRIVE_SEQ_KILL_EN
        if (kill) begin
            state_nxt = S_OFF;
            level_nxt = '0;
            cnt_nxt   = '0;
            done_nxt  = 1'b0;
        end
`endif

        for (int i = 0; i < SEGS; i++) begin
            seg_en_nxt[i] = (LVL_W'(i) < level_nxt);
        end
        busy_nxt = (state_nxt == S_RAMP_UP) || (state_nxt == S_RAMP_DOWN);
    end

endmodule

// File: tb/tb_inv_drive_seq.sv
// Randomized and directed bench for inv_drive_seq against a level/dwell reference model.
`timescale 1ns/1ps
module tb_inv_drive_seq;
    localparam int SEGS = 8;

    logic       clk;
    logic       rn;
    logic       en;
    logic [3:0] step;
`ifdef INV_DRIVE_SEQ_KILL_EN
    logic       kill;
`endif
    logic [7:0] seg_en;
    logic [3:0] level;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    // reference model: slice count, cycles left before next change, ramping flag
    int m_lvl;
    int m_wait;
    bit m_ramp;
    bit m_done;

    inv_drive_seq #(.SEGS(SEGS), .STEP_W(4)) dut (
        .clk    (clk),
        .rn     (rn),
        .en     (en),
        .step   (step),
`ifdef INV_DRIVE_SEQ_KILL_EN
        .kill   (kill),
`endif
        .seg_en (seg_en),
        .level  (level),
        .busy   (busy),
        .done   (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic model_reset();
        m_lvl  = 0;
        m_wait = 0;
        m_ramp = 1'b0;
        m_done = 1'b0;
    endtask

    task automatic model_step(input logic e, input int s, input bit k);
        m_done = 1'b0;
        if (k) begin
            model_reset();
        end else if (!m_ramp) begin
            if ((m_lvl == 0 && e) || (m_lvl == SEGS && !e)) begin
                m_lvl  = m_lvl + (e ? 1 : -1);
                m_ramp = 1'b1;
                m_wait = s;
            end
        end else if (m_wait > 0) begin
            m_wait = m_wait - 1;
        end else begin
            m_lvl = m_lvl + (e ? 1 : -1);
            if (m_lvl == 0 || m_lvl == SEGS) begin
                m_ramp = 1'b0;
                m_done = 1'b1;
            end else begin
                m_wait = s;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [63:0] therm;
        therm = (64'd1 << m_lvl) - 64'd1;
        chk({tag, ".seg_en"}, 64'(seg_en), therm);
        chk({tag, ".level"},  64'(level),  64'(m_lvl));
        chk({tag, ".busy"},   64'(busy),   64'(m_ramp));
        chk({tag, ".done"},   64'(done),   64'(m_done));
    endtask

    // called at a falling edge; applies inputs for the next rising edge
    task automatic cycle(input logic e, input logic [3:0] s, input bit k, input string tag);
        en   = e;
        step = s;
`ifdef INV_DRIVE_SEQ_KILL_EN
        kill = k;
`endif
        model_step(e, int'(s), k);
        @(negedge clk);
        compare_all(tag);
    endtask

    // asynchronous reset pulse between clock edges; ends at a falling edge
    task automatic pulse_reset(input string tag);
        #2;
        rn = 1'b0;
        #1;
        chk({tag, ".async_seg_en"}, 64'(seg_en), 64'd0);
        chk({tag, ".async_level"},  64'(level),  64'd0);
        model_reset();
        @(negedge clk);
        compare_all({tag, ".held"});
        rn = 1'b1;
    endtask

    initial begin
        int   n;
        int   dones;
        int   since;
        int   busy_cnt;
        logic [3:0] prev;
        logic re;
        logic [3:0] rs;

        rn   = 1'b0;
        en   = 1'b0;
        step = 4'd0;
`ifdef INV_DRIVE_SEQ_KILL_EN
        kill = 1'b0;
`endif
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        rn = 1'b1;

        // STEP=0 full ramp up: one slice per edge
        busy_cnt = 0;
        for (int k = 1; k <= SEGS; k++) begin
            cycle(1'b1, 4'd0, 1'b0, "ramp0");
            chk("ramp0.therm", 64'(seg_en), (64'd1 << k) - 64'd1);
            chk("ramp0.done_at_end", 64'(done), 64'(k == SEGS));
            busy_cnt += int'(busy);
        end
        chk("ramp0.busy_cycles", 64'(busy_cnt), 64'd7);

        // holding at ON changes nothing
        repeat (3) cycle(1'b1, 4'd5, 1'b0, "hold_on");

        // STEP=3 ramp down from ON
        n = 0;
        dones = 0;
        do begin
            cycle(1'b0, 4'd3, 1'b0, "down3");
            n++;
            dones += int'(done);
        end while (level != 0 && n < 60);
        chk("down3.cycles", 64'(n), 64'd29);
        chk("down3.dones", 64'(dones), 64'd1);

        // STEP=2 reversal at LEVEL=4
        n = 0;
        do begin
            cycle(1'b1, 4'd2, 1'b0, "rev_up");
            n++;
        end while (level != 4 && n < 40);
        chk("rev.reached4", 64'(level), 64'd4);
        n = 0;
        since = 0;
        prev = level;
        do begin
            cycle(1'b0, 4'd2, 1'b0, "rev_down");
            n++;
            since++;
            chk("rev.done_only_at_0", 64'(done), 64'(level == 0));
            if (level != prev) begin
                chk("rev.spacing", 64'(since), 64'd3);
                chk("rev.step_by_1", 64'(prev - level), 64'd1);
                since = 0;
                prev = level;
            end
        end while (level != 0 && n < 40);

        // asynchronous reset mid-ramp at LEVEL=5
        n = 0;
        do begin
            cycle(1'b1, 4'd0, 1'b0, "pre_rst");
            n++;
        end while (level != 5 && n < 20);
        chk("rst.reached5", 64'(level), 64'd5);
        pulse_reset("rst_mid");
        cycle(1'b1, 4'd0, 1'b0, "post_rst");
        chk("rst.restart_level", 64'(level), 64'd1);
        n = 0;
        do begin
            cycle(1'b0, 4'd0, 1'b0, "to_off");
            n++;
        end while ((level != 0 || busy) && n < 20);

        // STEP change 1->7 mid-dwell
        cycle(1'b1, 4'd1, 1'b0, "stepchg");
        chk("stepchg.first", 64'(level), 64'd1);
        cycle(1'b1, 4'd7, 1'b0, "stepchg");
        chk("stepchg.dwell_a", 64'(level), 64'd1);
        cycle(1'b1, 4'd7, 1'b0, "stepchg");
        chk("stepchg.dwell_b", 64'(level), 64'd2);
        n = 0;
        do begin
            cycle(1'b1, 4'd7, 1'b0, "stepchg");
            n++;
        end while (level == 2 && n < 20);
        chk("stepchg.next_dwell", 64'(n), 64'd8);

`ifdef INV_DRIVE_SEQ_KILL_EN
        n = 0;
        do begin
            cycle(1'b1, 4'd0, 1'b0, "kill_pre");
            n++;
        end while (level != SEGS && n < 40);
        cycle(1'b1, 4'd0, 1'b1, "kill");
        chk("kill.seg_en", 64'(seg_en), 64'd0);
        chk("kill.done", 64'(done), 64'd0);
        repeat (3) cycle(1'b1, 4'd0, 1'b1, "kill_hold");
        cycle(1'b1, 4'd0, 1'b0, "kill_rel");
        chk("kill.restart_level", 64'(level), 64'd1);
`endif

        // randomized traffic with occasional reversals, step changes and resets
        re = en;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 19) == 0) re = ~re;
            if ($urandom_range(0, 9) == 0) rs = 4'($urandom_range(0, 15));
            else rs = 4'($urandom_range(0, 2));
            if ($urandom_range(0, 599) == 0) begin
                pulse_reset("rand_rst");
            end else begin
`ifdef INV_DRIVE_SEQ_KILL_EN
                cycle(re, rs, ($urandom_range(0, 199) == 0), "rand");
`else
                cycle(re, rs, 1'b0, "rand");
`endif
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
